mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
Arbitrates a single shared data-memory port between two requesters: port 0 is the CPU MEM stage and port 1 is a loader/DMA engine (UART bootloader, debug writer). It sequences each access, waits out the memory read latency, and returns read data to the owning port. It drives a stall to the pipeline while the CPU's access is pending. It sits between the MEM stage and DataMemory and is the only master of the memory port.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
READ_LAT, 1, memory read latency in cycles from accept to data; legal range 1..4
MAX_LOCK, 8, maximum consecutive port-1 beats under p1_lock while port 0 waits; legal range 1..255

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
p0_req  in  1  CPU request
p0_we  in  1  CPU write enable (0 = read)
p0_addr  in  ADDR_W  CPU address
p0_wdata  in  DATA_W  CPU write data
p0_gnt  out  1  CPU request accepted this cycle
p0_rvalid  out  1  CPU read data valid
p0_rdata  out  DATA_W  CPU read data
p1_req, p1_we, p1_addr, p1_wdata, p1_gnt, p1_rvalid, p1_rdata  same as port 0, for the loader
p1_lock  in  1  loader requests to keep ownership for the next beat
cpu_stall  out  1  hold the IF..MEM pipeline
mem_en  out  1  memory command valid
mem_we  out  1  memory write
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid READ_LAT cycles after accept

Behaviour:
- Reset (reset=0, asynchronous): FSM=IDLE, last=1, lock_cnt=0, lat_cnt=0, owner=0.
- Reset values of all outputs: gnt, rvalid, mem_en, mem_we, cpu_stall = 0; rdata, mem_addr, mem_wdata = 0.
- FSM states: IDLE and RD_WAIT. Requests are accepted only in IDLE.
- Arbitration in IDLE:
  - Only one port requesting: that port wins.
  - Both requesting: the winner is the port other than `last`.
  - Lock override: if last=1, p1_lock=1 and lock_cnt<MAX_LOCK, port 1 wins.
- Accept cycle (combinational):
  - Drive gnt_w=1 and mem_en=1.
  - Drive mem_we/mem_addr/mem_wdata from the winner.
  - Register last=w.
  - lock_cnt: increments on a port-1 accept with p1_lock=1, saturating at MAX_LOCK. Clears on any port-0 accept, or on a port-1 accept with p1_lock=0.
- Write: completes in the accept cycle; FSM stays in IDLE.
- Read: FSM→RD_WAIT, owner=w, lat_cnt=READ_LAT-1.
  - Each cycle in RD_WAIT: if lat_cnt=0, rvalid_owner=1 and rdata_owner=mem_rdata (combinational), then →IDLE; else lat_cnt decrements.
  - Net latency: accept at cycle T gives rvalid at T+READ_LAT.
- Requests in RD_WAIT: ignored, no gnt.
- Requester protocol: hold req/we/addr/wdata stable until gnt. Remove or replace the request by the cycle after gnt (write) or after rvalid (read).
- When not selected: rdata outputs hold 0.
- cpu_stall = p0_req & ~((p0_gnt & p0_we) | p0_rvalid), combinational. cpu_stall is therefore 0 in the cycle the CPU access completes.
- Port 1 is never stalled by cpu_stall.
- Reset mid-RD_WAIT: the pending rvalid is discarded; no response is issued after reset release.
- Back-to-back: a read's rvalid cycle is RD_WAIT, so the next accept is no earlier than the following cycle. Writes may be accepted on consecutive cycles.
- Starvation bound: with p1_lock held, port 0 waits at most MAX_LOCK+1 accepts.

Optional Feature:
MEM_ARB_PERF_CNT_EN:
- Defined: adds outputs conflict_cnt[15:0] and stall_cnt[15:0], both saturating at 16'hFFFF and cleared by reset.
  - conflict_cnt increments each IDLE cycle with p0_req&p1_req.
  - stall_cnt increments each cycle cpu_stall=1.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- READ_LAT=1; p0 read addr 0x40000010, mem returns 0xDEADBEEF → p0_gnt at T, p0_rvalid and p0_rdata=0xDEADBEEF at T+1, cpu_stall=1 at T, 0 at T+1.
- p0 write 0x10=0x1234 and p1 write 0x20=0x5678 in the same cycle after reset (last=1) → port 0 accepted first, port 1 next cycle; mem sees two writes, cpu_stall=0 in the accept cycle.
- p1_lock=1 with continuous p1 reads, p0 requesting, MAX_LOCK=8, READ_LAT=1 → 8 port-1 beats, then p0_gnt; port 0 waits ≤18 cycles.
- READ_LAT=3, p1 read accepted at T, p0_req raised at T+1 → no p0_gnt until T+4; p1_rvalid exactly at T+3.
- reset driven 0 at T+1 of a READ_LAT=3 read → no rvalid afterwards, all outputs 0, FSM accepts a new request on the first cycle after release.
- MEM_ARB_PERF_CNT_EN defined, 5 conflict cycles → conflict_cnt=5; stall_cnt equals the cpu_stall high count.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: two-port arbiter for the single shared data-memory port.
// Port 0 is the CPU MEM stage and port 1 is the loader/DMA engine.
//
// Ports:
//   clk, reset           clock and asynchronous active-low reset
//   p0_* / p1_*          requester ports: req/we/addr/wdata in,
//                        gnt/rvalid/rdata out; p1_lock keeps port 1
//                        in ownership for the next beat
//   cpu_stall            holds IF..MEM while the CPU access is pending
//   mem_*                memory command port; mem_rdata is valid
//                        READ_LAT cycles after the accept cycle
//
// Optional build macro MEM_ARB_PERF_CNT_EN adds the saturating
// conflict_cnt and stall_cnt outputs.
module mem_bus_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int READ_LAT = 1,
    parameter int MAX_LOCK = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    input  logic              p1_lock,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              cpu_stall,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef MEM_ARB_PERF_CNT_EN
    ,
    output logic [15:0]       conflict_cnt,
    output logic [15:0]       stall_cnt
`endif
);

    localparam logic [0:0] IDLE     = 1'b0;
    localparam logic [0:0] RD_WAIT  = 1'b1;
    localparam logic [7:0] LOCK_MAX = 8'(MAX_LOCK);
    localparam logic [1:0] LAT_INIT = 2'(READ_LAT - 1);

    logic [0:0] state_q, state_d;
    logic       last_q, last_d;
    logic       owner_q, owner_d;
    logic [7:0] lock_cnt_q, lock_cnt_d;
    logic [1:0] lat_cnt_q, lat_cnt_d;

    logic run;
    logic accept;
    logic rsp;
    logic win;
    logic sel_we;

    always_comb begin
        // Outputs are forced quiet while reset is held.
        run    = reset;
        // Port 1 wins when alone, when port 0 had the last beat,
        // or when its lock is still within budget.
        win    = p1_req & (~p0_req | ~last_q |
                           (p1_lock & (lock_cnt_q < LOCK_MAX)));
        accept = run & (state_q == IDLE) & (p0_req | p1_req);
        rsp    = run & (state_q == RD_WAIT) & (lat_cnt_q == 2'd0);
        sel_we = win ? p1_we : p0_we;

        p0_gnt    = accept & ~win;
        p1_gnt    = accept & win;
        mem_en    = accept;
        mem_we    = accept & sel_we;
        mem_addr  = accept ? (win ? p1_addr : p0_addr) : '0;
        mem_wdata = accept ? (win ? p1_wdata : p0_wdata) : '0;

        p0_rvalid = rsp & ~owner_q;
        p1_rvalid = rsp & owner_q;
        p0_rdata  = p0_rvalid ? mem_rdata : '0;
        p1_rdata  = p1_rvalid ? mem_rdata : '0;

        cpu_stall = run & p0_req &
                    ~((p0_gnt & p0_we) | p0_rvalid);

        state_d    = state_q;
        last_d     = last_q;
        owner_d    = owner_q;
        lock_cnt_d = lock_cnt_q;
        lat_cnt_d  = lat_cnt_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    last_d = win;
                    if (win & p1_lock) begin
                        lock_cnt_d = (lock_cnt_q == LOCK_MAX) ?
                                     lock_cnt_q : lock_cnt_q + 8'd1;
                    end else begin
                        lock_cnt_d = 8'd0;
                    end
                    if (!sel_we) begin
                        state_d   = RD_WAIT;
                        owner_d   = win;
                        lat_cnt_d = LAT_INIT;
                    end
                end
            end
            RD_WAIT: begin
                if (lat_cnt_q == 2'd0) begin
                    state_d = IDLE;
                end else begin
                    lat_cnt_d = lat_cnt_q - 2'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            last_q     <= 1'b1;
            owner_q    <= 1'b0;
            lock_cnt_q <= 8'd0;
            lat_cnt_q  <= 2'd0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            owner_q    <= owner_d;
            lock_cnt_q <= lock_cnt_d;
            lat_cnt_q  <= lat_cnt_d;
        end
    end

`ifdef MEM_ARB_PERF_CNT_EN
    logic [15:0] conflict_cnt_q, conflict_cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        conflict_cnt_d = conflict_cnt_q;
        stall_cnt_d    = stall_cnt_q;
        if ((state_q == IDLE) && p0_req && p1_req &&
            (conflict_cnt_q != 16'hFFFF)) begin
            conflict_cnt_d = conflict_cnt_q + 16'd1;
        end
        if (cpu_stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            conflict_cnt_q <= 16'd0;
            stall_cnt_q    <= 16'd0;
        end else begin
            conflict_cnt_q <= conflict_cnt_d;
            stall_cnt_q    <= stall_cnt_d;
        end
    end

    assign conflict_cnt = conflict_cnt_q;
    assign stall_cnt    = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed plus random checks of mem_bus_arbiter.
// Instance 0 uses READ_LAT=1/MAX_LOCK=8, instance 1 READ_LAT=3/MAX_LOCK=3.
module tb_mem_bus_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [1:0]  p0_req, p0_we, p0_gnt, p0_rvalid;
    logic [1:0]  p1_req, p1_we, p1_gnt, p1_rvalid, p1_lock;
    logic [1:0]  cpu_stall, mem_en, mem_we;
    logic [31:0] p0_addr [2];
    logic [31:0] p0_wdata [2];
    logic [31:0] p0_rdata [2];
    logic [31:0] p1_addr [2];
    logic [31:0] p1_wdata [2];
    logic [31:0] p1_rdata [2];
    logic [31:0] mem_addr [2];
    logic [31:0] mem_wdata [2];
    logic [31:0] mem_rdata [2];
`ifdef MEM_ARB_PERF_CNT_EN
    logic [15:0] conflict_cnt [2];
    logic [15:0] stall_cnt [2];
`endif

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_bus_arbiter #(
            .ADDR_W(32), .DATA_W(32),
            .READ_LAT(g == 0 ? 1 : 3),
            .MAX_LOCK(g == 0 ? 8 : 3)
        ) u_dut (
            .clk(clk), .reset(reset),
            .p0_req(p0_req[g]), .p0_we(p0_we[g]),
            .p0_addr(p0_addr[g]), .p0_wdata(p0_wdata[g]),
            .p0_gnt(p0_gnt[g]), .p0_rvalid(p0_rvalid[g]),
            .p0_rdata(p0_rdata[g]),
            .p1_req(p1_req[g]), .p1_we(p1_we[g]),
            .p1_addr(p1_addr[g]), .p1_wdata(p1_wdata[g]),
            .p1_lock(p1_lock[g]),
            .p1_gnt(p1_gnt[g]), .p1_rvalid(p1_rvalid[g]),
            .p1_rdata(p1_rdata[g]),
            .cpu_stall(cpu_stall[g]),
            .mem_en(mem_en[g]), .mem_we(mem_we[g]),
            .mem_addr(mem_addr[g]), .mem_wdata(mem_wdata[g]),
            .mem_rdata(mem_rdata[g])
`ifdef MEM_ARB_PERF_CNT_EN
            ,
            .conflict_cnt(conflict_cnt[g]),
            .stall_cnt(stall_cnt[g])
`endif
        );
    end

    int rl [2] = '{1, 3};
    int ml [2] = '{8, 3};

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    // reference model: pending read due at an absolute cycle
    bit          m_busy [2];
    bit          m_own [2];
    bit          m_last [2];
    int          m_due [2];
    int          m_streak [2];
    logic [31:0] m_addr [2];
    int          m_conf [2];
    int          m_stall [2];

    // requester drivers
    bit          act [2][2];
    bit          dwe [2][2];
    logic [31:0] dad [2][2];
    logic [31:0] dwd [2][2];
    bit          done [2][2];
    bit          rep [2];
    bit          rep_we [2];
    bit          gen_en;
    bit          lock_v;

    // observed event log for directed checks
    int          last_g [2][2];
    int          cnt_g [2][2];
    int          last_rv [2][2];
    int          cnt_rv [2][2];
    logic [31:0] rv_data [2][2];

    function automatic logic [31:0] memf(logic [31:0] a);
        if (a == 32'h4000_0010) return 32'hDEAD_BEEF;
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    task automatic chk(input string tag, input int k,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s[%0d] observed=%h expected=%h",
                   tag, k, obs, exp);
        end
    endtask

    task automatic start(input int k, input int p, input bit we);
        act[k][p] = 1'b1;
        dwe[k][p] = we;
        dad[k][p] = $urandom;
        dwd[k][p] = $urandom;
    endtask

    task automatic drive();
        for (int k = 0; k < 2; k++) begin
            for (int p = 0; p < 2; p++) begin
                if (done[k][p]) begin
                    done[k][p] = 1'b0;
                    act[k][p]  = 1'b0;
                    if (rep[p]) start(k, p, rep_we[p]);
                end
                if (!act[k][p] && gen_en &&
                    $urandom_range(0, 1) == 1)
                    start(k, p, 1'($urandom_range(0, 1)));
            end
            p0_req[k]   = act[k][0];
            p0_we[k]    = dwe[k][0];
            p0_addr[k]  = dad[k][0];
            p0_wdata[k] = dwd[k][0];
            p1_req[k]   = act[k][1];
            p1_we[k]    = dwe[k][1];
            p1_addr[k]  = dad[k][1];
            p1_wdata[k] = dwd[k][1];
            p1_lock[k]  = lock_v;
            mem_rdata[k] = (m_busy[k] && cyc == m_due[k]) ?
                           memf(m_addr[k]) : $urandom;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            logic g0, g1, v0, v1, en, we, st, w;
            logic [31:0] d0, d1, ad, wd;
            g0 = 0; g1 = 0; v0 = 0; v1 = 0;
            en = 0; we = 0; st = 0; w = 0;
            d0 = 0; d1 = 0; ad = 0; wd = 0;
            if (reset) begin
                if (m_busy[k]) begin
                    if (cyc == m_due[k]) begin
                        if (m_own[k]) begin
                            v1 = 1; d1 = memf(m_addr[k]);
                        end else begin
                            v0 = 1; d0 = memf(m_addr[k]);
                        end
                    end
                end else if (p0_req[k] || p1_req[k]) begin
                    if (!p0_req[k]) w = 1;
                    else if (!p1_req[k]) w = 0;
                    else if (m_last[k] && p1_lock[k] &&
                             m_streak[k] < ml[k]) w = 1;
                    else w = !m_last[k];
                    en = 1;
                    g0 = !w;
                    g1 = w;
                    we = w ? p1_we[k] : p0_we[k];
                    ad = w ? p1_addr[k] : p0_addr[k];
                    wd = w ? p1_wdata[k] : p0_wdata[k];
                end
                st = p0_req[k] && !((g0 && p0_we[k]) || v0);
            end
            chk("p0_gnt", k, p0_gnt[k], g0);
            chk("p1_gnt", k, p1_gnt[k], g1);
            chk("p0_rvalid", k, p0_rvalid[k], v0);
            chk("p1_rvalid", k, p1_rvalid[k], v1);
            chk("p0_rdata", k, p0_rdata[k], d0);
            chk("p1_rdata", k, p1_rdata[k], d1);
            chk("mem_en", k, mem_en[k], en);
            chk("cpu_stall", k, cpu_stall[k], st);
            if (en || !reset) begin
                chk("mem_we", k, mem_we[k], we);
                chk("mem_addr", k, mem_addr[k], ad);
                chk("mem_wdata", k, mem_wdata[k], wd);
            end
`ifdef MEM_ARB_PERF_CNT_EN
            chk("conflict_cnt", k, conflict_cnt[k],
                reset ? m_conf[k] : 0);
            chk("stall_cnt", k, stall_cnt[k],
                reset ? m_stall[k] : 0);
`endif
            if (p0_gnt[k] === 1'b1) begin
                last_g[k][0] = cyc; cnt_g[k][0]++;
            end
            if (p1_gnt[k] === 1'b1) begin
                last_g[k][1] = cyc; cnt_g[k][1]++;
            end
            if (p0_rvalid[k] === 1'b1) begin
                last_rv[k][0] = cyc; cnt_rv[k][0]++;
                rv_data[k][0] = p0_rdata[k];
            end
            if (p1_rvalid[k] === 1'b1) begin
                last_rv[k][1] = cyc; cnt_rv[k][1]++;
                rv_data[k][1] = p1_rdata[k];
            end
            done[k][0] = (g0 && p0_we[k]) || v0;
            done[k][1] = (g1 && p1_we[k]) || v1;
            if (!reset) begin
                m_busy[k] = 0; m_last[k] = 1; m_own[k] = 0;
                m_streak[k] = 0; m_conf[k] = 0; m_stall[k] = 0;
            end else begin
                if (!m_busy[k] && p0_req[k] && p1_req[k] &&
                    m_conf[k] < 65535) m_conf[k]++;
                if (st && m_stall[k] < 65535) m_stall[k]++;
                if (m_busy[k]) begin
                    if (cyc == m_due[k]) m_busy[k] = 0;
                end else if (en) begin
                    m_last[k] = w;
                    if (w && p1_lock[k])
                        m_streak[k] = (m_streak[k] < ml[k]) ?
                                      m_streak[k] + 1 : m_streak[k];
                    else
                        m_streak[k] = 0;
                    if (!we) begin
                        m_busy[k] = 1;
                        m_due[k]  = cyc + rl[k];
                        m_own[k]  = w;
                        m_addr[k] = ad;
                    end
                end
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) begin
            drive();
            tick();
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        for (int k = 0; k < 2; k++)
            for (int p = 0; p < 2; p++) begin
                act[k][p]  = 0;
                done[k][p] = 0;
            end
        run(2);
        reset = 1'b1;
    endtask

    initial begin
        int t, t2, bound;
        int c1 [2];
        int pre1 [2];
        bit got [2];
        int rv_sum;

        reset  = 1'b0;
        gen_en = 0;
        lock_v = 0;
        rep    = '{0, 0};
        rep_we = '{0, 0};
        for (int k = 0; k < 2; k++) begin
            m_busy[k] = 0; m_own[k] = 0; m_last[k] = 1;
            m_due[k] = 0; m_streak[k] = 0; m_addr[k] = 0;
            m_conf[k] = 0; m_stall[k] = 0;
            for (int p = 0; p < 2; p++) begin
                act[k][p] = 0; dwe[k][p] = 0; done[k][p] = 0;
                dad[k][p] = 0; dwd[k][p] = 0;
                last_g[k][p] = -1; cnt_g[k][p] = 0;
                last_rv[k][p] = -1; cnt_rv[k][p] = 0;
                rv_data[k][p] = 0;
            end
        end
        @(posedge clk);
        #1;
        run(3);
        reset = 1'b1;

        // single CPU read
        do_reset();
        t = cyc;
        for (int k = 0; k < 2; k++) begin
            act[k][0] = 1; dwe[k][0] = 0;
            dad[k][0] = 32'h4000_0010;
        end
        run(6);
        for (int k = 0; k < 2; k++) begin
            chk("tp1_gnt_cyc", k, last_g[k][0], t);
            chk("tp1_rv_cyc", k, last_rv[k][0], t + rl[k]);
            chk("tp1_rdata", k, rv_data[k][0], 32'hDEAD_BEEF);
        end

        // simultaneous writes right after reset
        do_reset();
        t = cyc;
        for (int k = 0; k < 2; k++) begin
            act[k][0] = 1; dwe[k][0] = 1;
            dad[k][0] = 32'h10; dwd[k][0] = 32'h1234;
            act[k][1] = 1; dwe[k][1] = 1;
            dad[k][1] = 32'h20; dwd[k][1] = 32'h5678;
        end
        run(4);
        for (int k = 0; k < 2; k++) begin
            chk("tp2_p0_cyc", k, last_g[k][0], t);
            chk("tp2_p1_cyc", k, last_g[k][1], t + 1);
        end

        // locked port-1 reads against a waiting CPU read
        do_reset();
        lock_v = 1;
        rep[1] = 1;
        rep_we[1] = 0;
        t = cyc;
        for (int k = 0; k < 2; k++) begin
            start(k, 1, 0);
            start(k, 0, 0);
            c1[k] = cnt_g[k][1];
            got[k] = 0;
            pre1[k] = -1;
        end
        for (int i = 0; i < 60 && !(got[0] && got[1]); i++) begin
            run(1);
            for (int k = 0; k < 2; k++)
                if (!got[k] && last_g[k][0] >= t) begin
                    got[k] = 1;
                    pre1[k] = cnt_g[k][1] - c1[k];
                end
        end
        for (int k = 0; k < 2; k++) begin
            bound = ml[k] * (rl[k] + 1) + 2;
            chk("tp3_p0_granted", k, got[k], 1);
            chk("tp3_p1_beats", k, pre1[k], ml[k]);
            chk("tp3_wait_ok", k,
                (last_g[k][0] - t) <= bound, 1);
        end
        rep[1] = 0;
        lock_v = 0;
        run(20);

        // CPU request arriving during a port-1 read
        do_reset();
        t = cyc;
        for (int k = 0; k < 2; k++) start(k, 1, 0);
        run(1);
        for (int k = 0; k < 2; k++) start(k, 0, 0);
        run(10);
        for (int k = 0; k < 2; k++) begin
            chk("tp4_p1_gnt", k, last_g[k][1], t);
            chk("tp4_p1_rv", k, last_rv[k][1], t + rl[k]);
            chk("tp4_p0_gnt", k, last_g[k][0], t + rl[k] + 1);
        end

        // reset during a pending read
        do_reset();
        t = cyc;
        for (int k = 0; k < 2; k++) start(k, 0, 0);
        run(1);
        reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            act[k][0] = 0; act[k][1] = 0;
        end
        rv_sum = cnt_rv[0][0] + cnt_rv[0][1] +
                 cnt_rv[1][0] + cnt_rv[1][1];
        run(3);
        reset = 1'b1;
        t2 = cyc;
        for (int k = 0; k < 2; k++) start(k, 1, 1);
        run(8);
        chk("tp5_no_rvalid", 0, cnt_rv[0][0] + cnt_rv[0][1] +
            cnt_rv[1][0] + cnt_rv[1][1], rv_sum);
        for (int k = 0; k < 2; k++)
            chk("tp5_first_gnt", k, last_g[k][1], t2);

        // randomized traffic against the model
        gen_en = 1;
        for (int i = 0; i < 3000; i++) begin
            lock_v = ($urandom_range(0, 3) != 0);
            if (i == 1500) do_reset();
            run(1);
        end
        gen_en = 0;
        lock_v = 0;
        run(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
